// File: rtl/aes_round_sequencer.sv
// Round controller for the AES encrypt datapath: launches ARK, BS and MC
// sub-blocks in order, supplies round indices and arbitrates statemt RAM.
module aes_round_sequencer #(
    parameter int CNT_W = 16,
    parameter int RND_W = 6
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    input  logic [1:0]       key_type,
    output logic             ark_start,
    output logic [RND_W-1:0] ark_n,
    input  logic             ark_done,
    output logic             bs_start,
    input  logic             bs_done,
    output logic             mc_start,
    output logic [RND_W-1:0] mc_n,
    input  logic             mc_done,
    output logic [1:0]       mem_sel,
    output logic [3:0]       round_o,
    output logic             err,
    output logic [CNT_W-1:0] busy_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARK0, S_BS, S_MC, S_BSF, S_ARKF, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       nr_q, nr_d;
    logic [3:0]       round_q, round_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] busy_q, busy_d;
    logic             ark_start_q, ark_start_d;
    logic             bs_start_q, bs_start_d;
    logic             mc_start_q, mc_start_d;
    logic [1:0]       mem_sel_q, mem_sel_d;
    logic [RND_W-1:0] ark_n_q, ark_n_d;
    logic [RND_W-1:0] mc_n_q, mc_n_d;
    logic             done_q, done_d;
    logic             launch;

    // Next-state, round bookkeeping and one-shot launch of each sub-block
    always_comb begin
        state_d     = state_q;
        nr_d        = nr_q;
        round_d     = round_q;
        err_d       = err_q;
        busy_d      = busy_q;
        ark_start_d = 1'b0;
        bs_start_d  = 1'b0;
        mc_start_d  = 1'b0;
        mem_sel_d   = 2'd0;
        ark_n_d     = ark_n_q;
        mc_n_d      = mc_n_q;
        done_d      = 1'b0;
        // done inputs are meaningless while the launch pulse is out
        launch      = ark_start_q | bs_start_q | mc_start_q;

        if (state_q != S_IDLE && busy_q != {CNT_W{1'b1}})
            busy_d = busy_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    round_d = 4'd0;
                    busy_d  = '0;
                    err_d   = 1'b0;
                    case (key_type)
                        2'd0:    nr_d = 4'd10;
                        2'd1:    nr_d = 4'd12;
                        2'd2:    nr_d = 4'd14;
                        default: nr_d = 4'd0;
                    endcase
                    if (key_type == 2'd3) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ARK0;
                    end
                end
            end
            S_ARK0: begin
                if (!launch && ark_done) begin
                    round_d = 4'd1;
                    state_d = S_BS;
                end
            end
            S_BS: begin
                if (!launch && bs_done)
                    state_d = S_MC;
            end
            S_MC: begin
                if (!launch && mc_done) begin
                    if (round_q == nr_q - 4'd1) begin
                        state_d = S_BSF;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = S_BS;
                    end
                end
            end
            S_BSF: begin
                if (!launch && bs_done) begin
                    round_d = nr_q;
                    state_d = S_ARKF;
                end
            end
            S_ARKF: begin
                if (!launch && ark_done)
                    state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                S_ARK0: begin
                    ark_start_d = 1'b1;
                    ark_n_d     = '0;
                end
                S_ARKF: begin
                    ark_start_d = 1'b1;
                    ark_n_d     = RND_W'(nr_q);
                end
                S_BS, S_BSF: bs_start_d = 1'b1;
                S_MC: begin
                    mc_start_d = 1'b1;
                    mc_n_d     = RND_W'(round_q);
                end
                default: ;
            endcase
        end

        case (state_d)
            S_ARK0, S_ARKF: mem_sel_d = 2'd1;
            S_BS, S_BSF:    mem_sel_d = 2'd2;
            S_MC:           mem_sel_d = 2'd3;
            default:        mem_sel_d = 2'd0;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= S_IDLE;
            nr_q        <= 4'd0;
            round_q     <= 4'd0;
            err_q       <= 1'b0;
            busy_q      <= '0;
            ark_start_q <= 1'b0;
            bs_start_q  <= 1'b0;
            mc_start_q  <= 1'b0;
            mem_sel_q   <= 2'd0;
            ark_n_q     <= '0;
            mc_n_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nr_q        <= nr_d;
            round_q     <= round_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            ark_start_q <= ark_start_d;
            bs_start_q  <= bs_start_d;
            mc_start_q  <= mc_start_d;
            mem_sel_q   <= mem_sel_d;
            ark_n_q     <= ark_n_d;
            mc_n_q      <= mc_n_d;
            done_q      <= done_d;
        end
    end

    assign ap_done     = done_q;
    assign ap_ready    = done_q;
    assign ap_idle     = (state_q == S_IDLE);
    assign ark_start   = ark_start_q;
    assign bs_start    = bs_start_q;
    assign mc_start    = mc_start_q;
    assign ark_n       = ark_n_q;
    assign mc_n        = mc_n_q;
    assign mem_sel     = mem_sel_q;
    assign round_o     = round_q;
    assign err         = err_q;
    assign busy_cycles = busy_q;

endmodule
